// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF       = 11;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 8;

  // Owner of a read port's response in the cycle after a grant.
  typedef enum logic [1:0] {
    RT_NONE = 2'd0,
    RT_IF   = 2'd1,
    RT_LS   = 2'd2,
    RT_DBG  = 2'd3
  } route_tag_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating wait counter for the debug client; boost is raised once the
// counter has reached the limit and stays up until the debug client is served.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic wait_cyc,
  input  logic clear,
  output logic boost
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count waits up to the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (wait_cyc && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign boost = (cnt_q == CntMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF, LS and DBG onto a 1W/2R synchronous data memory.
// Optional read-after-write forwarding: define MEM_ARB_FWD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_adrs,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_adrs,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_adrs,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] m_w_adrs,
  output logic [ADDR_W-1:0] m_r_adrs1,
  output logic [ADDR_W-1:0] m_r_adrs2,
  output logic [DATA_W-1:0] m_data_in,
  output logic              m_w_en,
  output logic              m_r_en1,
  output logic              m_r_en2,
  input  logic [DATA_W-1:0] m_data_out1,
  input  logic [DATA_W-1:0] m_data_out2
);

  logic ls_rd, ls_wr, dbg_rd, dbg_wr;
  logic boost;
  logic ls_rd_g, ls_wr_g, dbg_p1, dbg_p2, dbg_w;
  route_tag_e rt1_q, rt1_d, rt2_q, rt2_d;
  logic [DATA_W-1:0] rd1, rd2;

  assign ls_rd  = ls_req && !ls_we;
  assign ls_wr  = ls_req && ls_we;
  assign dbg_rd = dbg_req && !dbg_we;
  assign dbg_wr = dbg_req && dbg_we;

  mem_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .wait_cyc(dbg_req && !dbg_gnt),
    .clear   (dbg_gnt || !dbg_req),
    .boost   (boost)
  );

  // Grant decision; everything is held off while reset is asserted.
  always_comb begin
    if_gnt  = 1'b0;
    ls_rd_g = 1'b0;
    ls_wr_g = 1'b0;
    dbg_p1  = 1'b0;
    dbg_p2  = 1'b0;
    dbg_w   = 1'b0;
    if (resetn) begin
      if (boost) begin
        // Boosted DBG pre-empts IF on port 1 or an LS write on the write port.
        dbg_p1  = dbg_rd;
        dbg_w   = dbg_wr;
        if_gnt  = if_req && !dbg_rd;
        ls_rd_g = ls_rd;
        ls_wr_g = ls_wr && !dbg_wr;
      end else begin
        if_gnt  = if_req;
        ls_rd_g = ls_rd;
        ls_wr_g = ls_wr;
        if (dbg_rd) begin
          if (!if_req) begin
            dbg_p1 = 1'b1;
          end else if (!ls_rd) begin
            dbg_p2 = 1'b1;
          end
        end else if (dbg_wr && !ls_wr) begin
          dbg_w = 1'b1;
        end
      end
    end
  end

  assign ls_gnt  = ls_rd_g || ls_wr_g;
  assign dbg_gnt = dbg_p1 || dbg_p2 || dbg_w;

  // Steer granted requests onto memory ports; idle ports drive zero.
  always_comb begin
    m_r_en1   = if_gnt || dbg_p1;
    m_r_adrs1 = '0;
    if (dbg_p1) begin
      m_r_adrs1 = dbg_adrs;
    end else if (if_gnt) begin
      m_r_adrs1 = if_adrs;
    end
    m_r_en2   = ls_rd_g || dbg_p2;
    m_r_adrs2 = '0;
    if (dbg_p2) begin
      m_r_adrs2 = dbg_adrs;
    end else if (ls_rd_g) begin
      m_r_adrs2 = ls_adrs;
    end
    m_w_en    = ls_wr_g || dbg_w;
    m_w_adrs  = '0;
    m_data_in = '0;
    if (dbg_w) begin
      m_w_adrs  = dbg_adrs;
      m_data_in = dbg_wdata;
    end else if (ls_wr_g) begin
      m_w_adrs  = ls_adrs;
      m_data_in = ls_wdata;
    end
  end

  // Route tags for the responses due next cycle.
  always_comb begin
    rt1_d = RT_NONE;
    rt2_d = RT_NONE;
    if (dbg_p1) begin
      rt1_d = RT_DBG;
    end else if (if_gnt) begin
      rt1_d = RT_IF;
    end
    if (dbg_p2) begin
      rt2_d = RT_DBG;
    end else if (ls_rd_g) begin
      rt2_d = RT_LS;
    end
  end

  // Route tag registers; reset drops any response in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rt1_q <= RT_NONE;
      rt2_q <= RT_NONE;
    end else begin
      rt1_q <= rt1_d;
      rt2_q <= rt2_d;
    end
  end

`ifdef MEM_ARB_FWD_EN
  logic [DATA_W-1:0] fwd_data_q;
  logic              fwd1_q, fwd2_q;

  // Capture the write and whether each read port hit the same address.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fwd_data_q <= '0;
      fwd1_q     <= 1'b0;
      fwd2_q     <= 1'b0;
    end else begin
      fwd_data_q <= m_data_in;
      fwd1_q     <= m_w_en && m_r_en1 && (m_r_adrs1 == m_w_adrs);
      fwd2_q     <= m_w_en && m_r_en2 && (m_r_adrs2 == m_w_adrs);
    end
  end

  assign rd1 = fwd1_q ? fwd_data_q : m_data_out1;
  assign rd2 = fwd2_q ? fwd_data_q : m_data_out2;
`else
  assign rd1 = m_data_out1;
  assign rd2 = m_data_out2;
`endif

  // Return read data to whichever client each port served last cycle.
  always_comb begin
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    ls_rvalid  = 1'b0;
    ls_rdata   = '0;
    dbg_rvalid = 1'b0;
    dbg_rdata  = '0;
    if (resetn) begin
      if (rt1_q == RT_IF) begin
        if_rvalid = 1'b1;
        if_rdata  = rd1;
      end else if (rt1_q == RT_DBG) begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = rd1;
      end
      if (rt2_q == RT_LS) begin
        ls_rvalid = 1'b1;
        ls_rdata  = rd2;
      end else if (rt2_q == RT_DBG) begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = rd2;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural memory and model.
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 8;
`ifdef MEM_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic if_req, ls_req, ls_we, dbg_req, dbg_we;
  logic [AW-1:0] if_adrs, ls_adrs, dbg_adrs;
  logic [DW-1:0] ls_wdata, dbg_wdata;
  logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] if_rdata, ls_rdata, dbg_rdata;
  logic [AW-1:0] m_w_adrs, m_r_adrs1, m_r_adrs2;
  logic [DW-1:0] m_data_in, m_data_out1, m_data_out2;
  logic m_w_en, m_r_en1, m_r_en2;

  int checks = 0;
  int passed = 0;
  int if_rv_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .resetn     (resetn),
    .if_req     (if_req),
    .if_adrs    (if_adrs),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_adrs    (ls_adrs),
    .ls_wdata   (ls_wdata),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_adrs   (dbg_adrs),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .m_w_adrs   (m_w_adrs),
    .m_r_adrs1  (m_r_adrs1),
    .m_r_adrs2  (m_r_adrs2),
    .m_data_in  (m_data_in),
    .m_w_en     (m_w_en),
    .m_r_en1    (m_r_en1),
    .m_r_en2    (m_r_en2),
    .m_data_out1(m_data_out1),
    .m_data_out2(m_data_out2)
  );

  // Physical memory: read-first, 1-cycle read, outputs hold when not enabled.
  logic [DW-1:0] mem [2048];
  always @(posedge clk) begin
    if (m_r_en1) m_data_out1 <= mem[m_r_adrs1];
    if (m_r_en2) m_data_out2 <= mem[m_r_adrs2];
    if (m_w_en) mem[m_w_adrs] <= m_data_in;
  end

  task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    chk_w(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Client-level model: golden memory, pending responses and DBG wait count.
  logic [DW-1:0] gmem [2048];
  int            m_cnt = 0;
  logic          p_if_v = 0, p_ls_v = 0, p_dbg_v = 0;
  logic [DW-1:0] p_if_d = 0, p_ls_d = 0, p_dbg_d = 0;
  logic          n_if_v = 0, n_ls_v = 0, n_dbg_v = 0, n_wv = 0, n_wait = 0;
  logic [DW-1:0] n_if_d = 0, n_ls_d = 0, n_dbg_d = 0, n_wd = 0;
  logic [AW-1:0] n_wa = 0;

  function automatic logic [DW-1:0] rdv(input logic [AW-1:0] a, input logic wv,
                                        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    return (FWD && wv && (wa == a)) ? wd : gmem[a];
  endfunction

  // Per-cycle compare against the model, then stage the model's next state.
  always @(negedge clk) begin : cmp
    logic e_if, e_ls, e_dbg, boost, wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    e_if = 0; e_ls = 0; e_dbg = 0;
    boost = (m_cnt == LIMIT);
    if (resetn) begin
      if (boost) begin
        e_dbg = dbg_req;
        e_if  = if_req && !(dbg_req && !dbg_we);
        e_ls  = ls_req && !(ls_we && dbg_req && dbg_we);
      end else begin
        e_if = if_req;
        e_ls = ls_req;
        if (dbg_req && !dbg_we) e_dbg = !if_req || !(ls_req && !ls_we);
        else if (dbg_req)       e_dbg = !(ls_req && ls_we);
      end
    end
    chk_b("if_gnt", if_gnt, e_if);
    chk_b("ls_gnt", ls_gnt, e_ls);
    chk_b("dbg_gnt", dbg_gnt, e_dbg);
    chk_b("if_rvalid", if_rvalid, p_if_v);
    chk_b("ls_rvalid", ls_rvalid, p_ls_v);
    chk_b("dbg_rvalid", dbg_rvalid, p_dbg_v);
    chk_w("if_rdata", if_rdata, p_if_v ? p_if_d : 32'd0);
    chk_w("ls_rdata", ls_rdata, p_ls_v ? p_ls_d : 32'd0);
    chk_w("dbg_rdata", dbg_rdata, p_dbg_v ? p_dbg_d : 32'd0);
    if (!resetn) begin
      chk_w("reset_en", {29'd0, m_w_en, m_r_en1, m_r_en2}, 32'd0);
      chk_w("reset_adr", {m_w_adrs, m_r_adrs1, m_r_adrs2}, 33'd0);
      chk_w("reset_din", m_data_in, 32'd0);
    end
    if (if_rvalid) if_rv_cnt++;
    wv = 0; wa = 0; wd = 0;
    if (e_ls && ls_we) begin wv = 1; wa = ls_adrs; wd = ls_wdata; end
    if (e_dbg && dbg_we) begin wv = 1; wa = dbg_adrs; wd = dbg_wdata; end
    n_if_v  <= e_if;
    n_if_d  <= rdv(if_adrs, wv, wa, wd);
    n_ls_v  <= e_ls && !ls_we;
    n_ls_d  <= rdv(ls_adrs, wv, wa, wd);
    n_dbg_v <= e_dbg && !dbg_we;
    n_dbg_d <= rdv(dbg_adrs, wv, wa, wd);
    n_wv    <= wv;
    n_wa    <= wa;
    n_wd    <= wd;
    n_wait  <= dbg_req && !e_dbg;
  end

  // Commit the staged model state at the clock edge the DUT samples.
  always @(posedge clk) begin
    if (!resetn) begin
      m_cnt <= 0; p_if_v <= 0; p_ls_v <= 0; p_dbg_v <= 0;
    end else begin
      p_if_v <= n_if_v; p_if_d <= n_if_d;
      p_ls_v <= n_ls_v; p_ls_d <= n_ls_d;
      p_dbg_v <= n_dbg_v; p_dbg_d <= n_dbg_d;
      if (n_wv) gmem[n_wa] <= n_wd;
      m_cnt <= n_wait ? ((m_cnt == LIMIT) ? m_cnt : m_cnt + 1) : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 0; if_adrs = 0;
    ls_req = 0; ls_we = 0; ls_adrs = 0; ls_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_adrs = 0; dbg_wdata = 0;
  endtask

  function automatic logic [31:0] lit_stream(input int i);
    case (i)
      2:       return 32'h1234_5678;
      5:       return 32'hAAAA_0000;
      6:       return 32'h0000_BBBB;
      7:       return 32'h7777_0007;
      default: return 32'hC0DE_0000 | i;
    endcase
  endfunction

  initial begin
    int rv0;
    resetn = 0;
    idle();
    for (int i = 0; i < 2048; i++) begin
      mem[i]  = 32'hC0DE_0000 | i;
      gmem[i] = 32'hC0DE_0000 | i;
    end
    mem[5] = 32'hAAAA_0000;  gmem[5] = 32'hAAAA_0000;
    mem[6] = 32'h0000_BBBB;  gmem[6] = 32'h0000_BBBB;
    mem[7] = 32'h7777_0007;  gmem[7] = 32'h7777_0007;
    mem[16] = 32'h0;         gmem[16] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1;
    tick();

    // IF and LS parallel reads.
    if_req = 1; if_adrs = 11'h005;
    ls_req = 1; ls_we = 0; ls_adrs = 11'h006;
    @(negedge clk);
    chk_b("t1_if_gnt", if_gnt, 1'b1);
    chk_b("t1_ls_gnt", ls_gnt, 1'b1);
    tick(); idle();
    @(negedge clk);
    chk_b("t1_if_rv", if_rvalid, 1'b1);
    chk_w("t1_if_rd", if_rdata, 32'hAAAA_0000);
    chk_b("t1_ls_rv", ls_rvalid, 1'b1);
    chk_w("t1_ls_rd", ls_rdata, 32'h0000_BBBB);
    tick();

    // LS write alongside DBG read on port 1.
    ls_req = 1; ls_we = 1; ls_adrs = 11'h002; ls_wdata = 32'h1234_5678;
    dbg_req = 1; dbg_we = 0; dbg_adrs = 11'h007;
    @(negedge clk);
    chk_b("t2_ls_gnt", ls_gnt, 1'b1);
    chk_b("t2_dbg_gnt", dbg_gnt, 1'b1);
    chk_w("t2_port1", {20'd0, m_r_en1, m_r_adrs1}, {20'd0, 1'b1, 11'h007});
    tick(); idle();
    @(negedge clk);
    chk_b("t2_dbg_rv", dbg_rvalid, 1'b1);
    chk_w("t2_dbg_rd", dbg_rdata, 32'h7777_0007);
    tick();
    tick();

    // Starvation: DBG write blocked by continuous LS writes until boosted.
    if_req = 1; if_adrs = 11'h020;
    ls_req = 1; ls_we = 1; ls_adrs = 11'h030; ls_wdata = 32'h55;
    dbg_req = 1; dbg_we = 1; dbg_adrs = 11'h040; dbg_wdata = 32'h99;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk_b("t3_dbg_wait", dbg_gnt, 1'b0);
      tick();
    end
    @(negedge clk);
    chk_b("t3_dbg_boost", dbg_gnt, 1'b1);
    chk_b("t3_ls_held", ls_gnt, 1'b0);
    chk_b("t3_if_ok", if_gnt, 1'b1);
    tick();
    dbg_req = 0;
    @(negedge clk);
    chk_b("t3_ls_back", ls_gnt, 1'b1);
    tick(); idle();
    tick();

    // Same-cycle LS write and DBG read of one address.
    ls_req = 1; ls_we = 1; ls_adrs = 11'h010; ls_wdata = 32'hDEAD_BEEF;
    dbg_req = 1; dbg_we = 0; dbg_adrs = 11'h010;
    @(negedge clk);
    chk_b("t4_dbg_gnt", dbg_gnt, 1'b1);
    tick(); idle();
    @(negedge clk);
    chk_w("t4_dbg_rd", dbg_rdata, FWD ? 32'hDEAD_BEEF : 32'h0);
    tick();

    // Reset right after a grant drops the response.
    if_req = 1; if_adrs = 11'h003;
    @(negedge clk);
    chk_b("t5_if_gnt", if_gnt, 1'b1);
    #1 resetn = 0;
    tick();
    @(negedge clk);
    chk_b("t5_no_rv", if_rvalid, 1'b0);
    chk_b("t5_no_gnt", if_gnt, 1'b0);
    tick();
    resetn = 1;
    @(negedge clk);
    chk_b("t5_gnt_after", if_gnt, 1'b1);
    tick(); idle();
    @(negedge clk);
    chk_w("t5_rd_after", if_rdata, 32'hC0DE_0003);
    tick();

    // IF streaming 0x000..0x00F.
    rv0 = if_rv_cnt;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        if_req = 1; if_adrs = AW'(i);
      end else begin
        idle();
      end
      @(negedge clk);
      if (i < 16) chk_b("t6_gnt", if_gnt, 1'b1);
      if (i > 0) begin
        chk_b("t6_rv", if_rvalid, 1'b1);
        chk_w("t6_rd", if_rdata, lit_stream(i - 1));
      end
      tick();
    end
    chk_w("t6_rv_count", if_rv_cnt - rv0, 32'd16);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
